asteroid_spawn_sched: RTL and testbench

//  Schedules the shared pool of asteroid_move slots for the game top level.

---
 rtl/asteroid_spawn_sched_if.sv | 23 ++
 rtl/asteroid_spawn_sched.sv | 93 +++++++++
 tb/tb_asteroid_spawn_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/asteroid_spawn_sched_if.sv
// asteroid_spawn_sched_if: frame/slot control bundle between the game top level and the spawn scheduler
interface asteroid_spawn_sched_if #(
  parameter int NUM_SLOTS = 3
);
  logic                 frame_tick_i;
  logic                 halt_i;
  logic [4:0]           rand_i;
  logic [NUM_SLOTS-1:0] slot_done_i;
  logic [NUM_SLOTS-1:0] slot_active_o;
  logic [NUM_SLOTS-1:0] spawn_o;
  logic [9:0]           spawn_x_o;
  logic [2:0]           spawn_type_o;
  logic [2:0]           level_o;
  logic [3:0]           speed_o;
  modport master (
    output frame_tick_i, halt_i, rand_i, slot_done_i,
    input  slot_active_o, spawn_o, spawn_x_o, spawn_type_o, level_o, speed_o
  );
  modport slave (
    input  frame_tick_i, halt_i, rand_i, slot_done_i,
    output slot_active_o, spawn_o, spawn_x_o, spawn_type_o, level_o, speed_o
  );
endinterface

// File: rtl/asteroid_spawn_sched.sv
// asteroid_spawn_sched: frame-paced asteroid launcher with round-robin slot grant and rising difficulty
module asteroid_spawn_sched #(
  parameter int NUM_SLOTS     = 3,
  parameter int BASE_INTERVAL = 90,
  parameter int STEP          = 8,
  parameter int MIN_INTERVAL  = 20,
  parameter int LEVEL_FRAMES  = 600,
  parameter int MAX_LEVEL     = 7
) (
  input logic                   clk,
  input logic                   reset,
  asteroid_spawn_sched_if.slave bus
);
  localparam int PW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  typedef enum logic {HALTED, RUN} state_e;
  state_e               state_q, state_d;
  logic [7:0]           timer_q, timer_d, timer_dec, ival;
  logic [9:0]           frame_q, frame_d;
  logic [2:0]           level_q, level_d;
  logic [PW-1:0]        rr_q, rr_d, gidx;
  logic [NUM_SLOTS-1:0] active_q, active_d, spawn_q, grant, free;
  logic [9:0]           x_q, x_d;
  logic [2:0]           type_q, type_d;
  logic signed [8:0]    ival_s;
  logic                 tick, found;
  // halt blocks a coincident frame_tick in the same cycle it rises
  assign tick      = state_q == RUN && !bus.halt_i && bus.frame_tick_i;
  assign free      = ~active_q | bus.slot_done_i;
  assign ival_s    = 9'(BASE_INTERVAL) - 9'(level_q) * 9'(STEP);
  assign ival      = ival_s < $signed(9'(MIN_INTERVAL)) ? 8'(MIN_INTERVAL) : ival_s[7:0];
  assign timer_dec = timer_q == '0 ? '0 : timer_q - 8'd1;
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (!found && free[PW'((int'(rr_q) + k) % NUM_SLOTS)]) begin
        found = 1'b1;
        gidx  = PW'((int'(rr_q) + k) % NUM_SLOTS);
      end
  end
  always_comb begin
    state_d = bus.halt_i ? HALTED : RUN;
    timer_d = timer_q;
    frame_d = frame_q;
    level_d = level_q;
    rr_d    = rr_q;
    x_d     = x_q;
    type_d  = type_q;
    grant   = '0;
    if (tick) begin
      frame_d = frame_q == 10'(LEVEL_FRAMES - 1) ? '0 : frame_q + 10'd1;
      level_d = frame_q == 10'(LEVEL_FRAMES - 1) && level_q != 3'(MAX_LEVEL) ? level_q + 3'd1 : level_q;
      timer_d = timer_dec;
      // a pending spawn (timer parked at 0) retries on every tick until a slot frees
      if (timer_dec == '0 && found) begin
        grant   = NUM_SLOTS'(1) << gidx;
        timer_d = ival;
        rr_d    = gidx == PW'(NUM_SLOTS - 1) ? '0 : gidx + PW'(1);
        x_d     = 10'd40 + 10'(bus.rand_i) * 10'd18;
        type_d  = bus.rand_i[4:2];
      end
    end
    active_d = (active_q & ~bus.slot_done_i) | grant;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= HALTED;
      timer_q  <= 8'(BASE_INTERVAL);
      frame_q  <= '0;
      level_q  <= '0;
      rr_q     <= '0;
      active_q <= '0;
      spawn_q  <= '0;
      x_q      <= '0;
      type_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      frame_q  <= frame_d;
      level_q  <= level_d;
      rr_q     <= rr_d;
      active_q <= active_d;
      spawn_q  <= grant;
      x_q      <= x_d;
      type_q   <= type_d;
    end
  assign bus.slot_active_o = active_q;
  assign bus.spawn_o       = spawn_q;
  assign bus.spawn_x_o     = x_q;
  assign bus.spawn_type_o  = type_q;
  assign bus.level_o       = level_q;
  assign bus.speed_o       = 4'(level_q) + 4'd1;
endmodule

// File: tb/tb_asteroid_spawn_sched.sv
// tb_asteroid_spawn_sched: directed and randomized checks of the spawn scheduler against a frame-level model
module tb_asteroid_spawn_sched;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  asteroid_spawn_sched_if #(.NUM_SLOTS(N)) bif();
  asteroid_spawn_sched #(.NUM_SLOTS(N)) dut (.clk(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit m_run;
  int m_timer, m_frames, m_rr, div_cnt, tick_no;
  time first_div;
  logic [N-1:0] m_act, exp_spawn;
  logic [9:0] exp_x;
  logic [2:0] exp_type, exp_level;
  int spawn_log[$];

  function automatic int level_of(int frames);
    return frames / 600 > 7 ? 7 : frames / 600;
  endfunction

  task automatic model_reset();
    m_run = 0; m_timer = 90; m_frames = 0; m_rr = 0; m_act = '0;
    exp_spawn = '0; exp_x = '0; exp_type = '0; exp_level = '0;
  endtask

  // advance one clock: update the frame-level model from the driven inputs, then compare
  task automatic step();
    logic [N-1:0] freev;
    int lvl, g;
    exp_spawn = '0;
    if (bif.frame_tick_i) tick_no++;
    if (m_run && !bif.halt_i && bif.frame_tick_i) begin
      lvl = level_of(m_frames);
      m_frames++;
      if (m_timer > 0) m_timer--;
      freev = ~m_act | bif.slot_done_i;
      g = -1;
      if (m_timer == 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && freev[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        exp_spawn[g] = 1'b1;
        m_rr = (g + 1) % N;
        m_timer = 90 - 8 * lvl < 20 ? 20 : 90 - 8 * lvl;
        exp_x = 10'(40 + 18 * int'(bif.rand_i));
        exp_type = bif.rand_i[4:2];
      end
    end
    m_act = (m_act & ~bif.slot_done_i) | exp_spawn;
    m_run = !bif.halt_i;
    exp_level = 3'(level_of(m_frames));
    @(posedge clk); #1;
    if (bif.spawn_o !== exp_spawn || bif.slot_active_o !== m_act || bif.spawn_x_o !== exp_x ||
        bif.spawn_type_o !== exp_type || bif.level_o !== exp_level || bif.speed_o !== 4'(exp_level) + 4'd1) begin
      if (div_cnt == 0) first_div = $time;
      div_cnt++;
    end
    if (bif.spawn_o !== '0) spawn_log.push_back(tick_no);
  endtask

  task automatic frame(int period, bit auto_done = 0);
    bif.frame_tick_i = 1'b1;
    bif.rand_i = 5'($urandom);
    step();
    bif.frame_tick_i = 1'b0;
    if (auto_done) begin
      bif.slot_done_i = m_act;
      step();
      bif.slot_done_i = '0;
    end
    repeat (period - 1 - int'(auto_done)) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.frame_tick_i = 0; bif.halt_i = 1; bif.rand_i = '0; bif.slot_done_i = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    div_cnt = 0;
    spawn_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bif.spawn_o !== 3'b000) begin errors++; $display("FAIL reset_spawn got=%b want=000", bif.spawn_o); end
    checks++; if (bif.slot_active_o !== 3'b000) begin errors++; $display("FAIL reset_active got=%b want=000", bif.slot_active_o); end
    checks++; if (bif.spawn_x_o !== 10'd0) begin errors++; $display("FAIL reset_x got=%0d want=0", bif.spawn_x_o); end
    checks++; if (bif.spawn_type_o !== 3'd0) begin errors++; $display("FAIL reset_type got=%0d want=0", bif.spawn_type_o); end
    checks++; if (bif.level_o !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", bif.level_o); end
    checks++; if (bif.speed_o !== 4'd1) begin errors++; $display("FAIL reset_speed got=%0d want=1", bif.speed_o); end
  endtask

  task automatic test_done_ignored();
    bif.halt_i = 0;
    step();
    bif.slot_done_i = 3'b111;
    step();
    bif.slot_done_i = '0;
    checks++; if (bif.slot_active_o !== 3'b000) begin errors++; $display("FAIL done_inactive got=%b want=000", bif.slot_active_o); end
  endtask

  task automatic test_first_spawn();
    do_reset();
    bif.halt_i = 0;
    step();
    repeat (89) frame(10);
    checks++; if (spawn_log.size() !== 0) begin errors++; $display("FAIL early_spawn got=%0d want=0", spawn_log.size()); end
    bif.frame_tick_i = 1; bif.rand_i = 5'd31;
    step();
    bif.frame_tick_i = 0;
    checks++; if (bif.spawn_o !== 3'b001) begin errors++; $display("FAIL first_spawn got=%b want=001", bif.spawn_o); end
    checks++; if (bif.slot_active_o !== 3'b001) begin errors++; $display("FAIL first_active got=%b want=001", bif.slot_active_o); end
    checks++; if (bif.spawn_x_o !== 10'd598) begin errors++; $display("FAIL x_max got=%0d want=598", bif.spawn_x_o); end
    checks++; if (bif.spawn_type_o !== 3'b111) begin errors++; $display("FAIL type_max got=%b want=111", bif.spawn_type_o); end
    step();
    checks++; if (bif.spawn_o !== 3'b000) begin errors++; $display("FAIL spawn_width got=%b want=000", bif.spawn_o); end
    checks++; if (bif.spawn_x_o !== 10'd598) begin errors++; $display("FAIL x_hold got=%0d want=598", bif.spawn_x_o); end
    repeat (8) step();
    checks++; if (div_cnt !== 0) begin errors++; $display("FAIL model_first diverged=%0d at=%0t", div_cnt, first_div); end
  endtask

  task automatic test_round_robin();
    repeat (89) frame(10);
    bif.frame_tick_i = 1; bif.rand_i = 5'd0;
    step();
    bif.frame_tick_i = 0;
    checks++; if (bif.spawn_o !== 3'b010) begin errors++; $display("FAIL rr_slot1 got=%b want=010", bif.spawn_o); end
    checks++; if (bif.spawn_x_o !== 10'd40) begin errors++; $display("FAIL x_min got=%0d want=40", bif.spawn_x_o); end
    repeat (9) step();
    repeat (89) frame(10);
    bif.frame_tick_i = 1; bif.rand_i = 5'($urandom);
    step();
    bif.frame_tick_i = 0;
    checks++; if (bif.spawn_o !== 3'b100) begin errors++; $display("FAIL rr_slot2 got=%b want=100", bif.spawn_o); end
    repeat (9) step();
    spawn_log.delete();
    repeat (90) frame(10);
    checks++; if (spawn_log.size() !== 0) begin errors++; $display("FAIL full_pool got=%0d spawns want=0", spawn_log.size()); end
    repeat (40) frame(10);
    bif.slot_done_i = 3'b010;
    step();
    bif.slot_done_i = '0;
    checks++; if (bif.slot_active_o !== 3'b101) begin errors++; $display("FAIL done_clear got=%b want=101", bif.slot_active_o); end
    bif.frame_tick_i = 1;
    step();
    bif.frame_tick_i = 0;
    checks++; if (bif.spawn_o !== 3'b010) begin errors++; $display("FAIL pending_spawn got=%b want=010", bif.spawn_o); end
    repeat (9) step();
    spawn_log.delete();
    repeat (90) frame(10);
    bif.frame_tick_i = 1; bif.slot_done_i = 3'b100;
    step();
    bif.frame_tick_i = 0; bif.slot_done_i = '0;
    checks++; if (bif.spawn_o !== 3'b100) begin errors++; $display("FAIL same_cycle_done got=%b want=100", bif.spawn_o); end
    checks++; if (bif.slot_active_o !== 3'b111) begin errors++; $display("FAIL same_cycle_active got=%b want=111", bif.slot_active_o); end
    checks++; if (spawn_log.size() !== 1) begin errors++; $display("FAIL retry_count got=%0d want=1", spawn_log.size()); end
    checks++; if (div_cnt !== 0) begin errors++; $display("FAIL model_rr diverged=%0d at=%0t", div_cnt, first_div); end
  endtask

  task automatic test_halt();
    do_reset();
    bif.halt_i = 0;
    step();
    repeat (120) frame(10);
    bif.halt_i = 1; bif.frame_tick_i = 1;
    step();
    bif.frame_tick_i = 0;
    repeat (9) step();
    for (int f = 0; f < 49; f++) begin
      frame(10);
      if (f == 20) begin
        bif.slot_done_i = 3'b001;
        step();
        bif.slot_done_i = '0;
      end
    end
    checks++; if (bif.slot_active_o !== 3'b000) begin errors++; $display("FAIL halt_done got=%b want=000", bif.slot_active_o); end
    checks++; if (spawn_log.size() !== 1) begin errors++; $display("FAIL halt_spawn got=%0d spawns want=1", spawn_log.size()); end
    bif.halt_i = 0;
    step();
    repeat (59) frame(10);
    checks++; if (spawn_log.size() !== 1) begin errors++; $display("FAIL halt_early got=%0d spawns want=1", spawn_log.size()); end
    bif.frame_tick_i = 1;
    step();
    bif.frame_tick_i = 0;
    checks++; if (bif.spawn_o !== 3'b010) begin errors++; $display("FAIL halt_resume got=%b want=010", bif.spawn_o); end
    repeat (9) step();
    checks++; if (div_cnt !== 0) begin errors++; $display("FAIL model_halt diverged=%0d at=%0t", div_cnt, first_div); end
  endtask

  task automatic test_levels();
    do_reset();
    bif.halt_i = 0;
    step();
    repeat (4200) frame(4, 1);
    checks++; if (bif.level_o !== 3'd7) begin errors++; $display("FAIL level_sat got=%0d want=7", bif.level_o); end
    checks++; if (bif.speed_o !== 4'd8) begin errors++; $display("FAIL speed_sat got=%0d want=8", bif.speed_o); end
    spawn_log.delete();
    repeat (100) frame(4, 1);
    checks++;
    if (spawn_log.size() < 3) begin errors++; $display("FAIL interval_spawns got=%0d want>=3", spawn_log.size()); end
    else if (spawn_log[1] - spawn_log[0] !== 34 || spawn_log[2] - spawn_log[1] !== 34) begin
      errors++; $display("FAIL interval_min got=%0d,%0d want=34", spawn_log[1] - spawn_log[0], spawn_log[2] - spawn_log[1]);
    end
    checks++; if (div_cnt !== 0) begin errors++; $display("FAIL model_levels diverged=%0d at=%0t", div_cnt, first_div); end
  endtask

  task automatic test_reset_in_flight();
    bit hit = 0;
    for (int f = 0; f < 60 && !hit; f++) begin
      bif.frame_tick_i = 1; bif.rand_i = 5'($urandom);
      step();
      bif.frame_tick_i = 0;
      if (bif.spawn_o !== '0) hit = 1;
      else begin
        bif.slot_done_i = m_act;
        step();
        bif.slot_done_i = '0;
        repeat (2) step();
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL flight_spawn got=none want=spawn within 60 frames"); end
    else begin
      reset = 1'b1;
      #1;
      checks++; if (bif.spawn_o !== 3'b000) begin errors++; $display("FAIL flight_spawn_clr got=%b want=000", bif.spawn_o); end
      checks++; if (bif.slot_active_o !== 3'b000) begin errors++; $display("FAIL flight_active got=%b want=000", bif.slot_active_o); end
      checks++; if (bif.level_o !== 3'd0) begin errors++; $display("FAIL flight_level got=%0d want=0", bif.level_o); end
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    bif.halt_i = 0;
    step();
    for (int f = 0; f < 3000; f++) begin
      if ($urandom_range(0, 19) == 0) bif.halt_i = ~bif.halt_i;
      bif.frame_tick_i = 1;
      bif.rand_i = 5'($urandom);
      bif.slot_done_i = $urandom_range(0, 5) == 0 ? N'($urandom) : '0;
      step();
      bif.frame_tick_i = 0;
      repeat ($urandom_range(1, 5)) begin
        bif.slot_done_i = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
        step();
      end
      bif.slot_done_i = '0;
    end
    checks++; if (spawn_log.size() < 10) begin errors++; $display("FAIL random_activity got=%0d spawns want>=10", spawn_log.size()); end
    checks++; if (div_cnt !== 0) begin errors++; $display("FAIL model_random diverged=%0d at=%0t", div_cnt, first_div); end
  endtask

  initial begin
    tick_no = 0;
    test_reset();
    test_done_ignored();
    test_first_spawn();
    test_round_robin();
    test_halt();
    test_levels();
    test_reset_in_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
